// File: rtl/seq_alu.sv
// Registered ALU with valid/ready operand handshake, shifts and NZCV-style flags.
// Define SEQ_ALU_MUL_EN to enable the iterative shift-add multiply on ctrl 4'b0101.
module seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [3:0]       ctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] busW,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    logic             rdy_q;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;
    logic [WIDTH:0]   sum;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        sum     = '0;
        case (ctrl)
            4'b0000: alu_res = busA & busB;
            4'b0001: alu_res = busA | busB;
            4'b0111: alu_res = busB;
            4'b0010: begin
                sum     = {1'b0, busA} + {1'b0, busB};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (busA[WIDTH-1] == busB[WIDTH-1]) && (alu_res[WIDTH-1] != busA[WIDTH-1]);
            end
            4'b0110: begin
                sum     = {1'b0, busA} + {1'b0, ~busB} + (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (busA[WIDTH-1] != busB[WIDTH-1]) && (alu_res[WIDTH-1] != busA[WIDTH-1]);
            end
            4'b0011: alu_res = busA << busB[SHW-1:0];
            4'b0100: alu_res = busA >> busB[SHW-1:0];
            default: alu_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic {IDLE, MUL_RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_sum;
    logic             is_mul;
    logic             mul_last;

    assign is_mul   = (ctrl == 4'b0101);
    assign mul_last = (cnt == SHW'(WIDTH - 1));
    assign mul_sum  = acc + (mb[0] ? ma : '0);
    assign in_ready = rdy_q && (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nxt = MUL_RUN;
            MUL_RUN: if (mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (accept && is_mul) begin
                cnt <= '0;
                ma  <= busA;
                mb  <= busB;
                acc <= '0;
            end else if (state == MUL_RUN) begin
                cnt <= cnt + SHW'(1);
                ma  <= ma << 1;
                mb  <= mb >> 1;
                acc <= mul_sum;
            end
        end
    end
`else
    assign in_ready = rdy_q;
`endif

    assign accept   = in_valid && in_ready;
    assign zero     = (busW == '0);
    assign negative = busW[WIDTH-1];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rdy_q     <= 1'b0;
            out_valid <= 1'b0;
            busW      <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b0;
        end else begin
            rdy_q     <= 1'b1;
            out_valid <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            // The last multiply step writes busW directly from the adder so the
            // result lands on the same edge as the final partial-product add.
            if (state == MUL_RUN && mul_last) begin
                busW      <= mul_sum;
                carry     <= 1'b0;
                overflow  <= 1'b0;
                err       <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept && !is_mul) begin
`else
            if (accept) begin
`endif
                busW      <= alu_res;
                carry     <= alu_c;
                overflow  <= alu_v;
                err       <= alu_err;
                out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=64: vector table for single-cycle ops,
// hand-written sequences for multiply, stray in_valid and reset abort.
module tb_seq_alu;
    logic        CLK;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] busA;
    logic [63:0] busB;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic [63:0] busW;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        err;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(64)) dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .busA(busA), .busB(busB), .ctrl(ctrl), .out_valid(out_valid),
        .busW(busW), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] w;
        logic [4:0]  f;   // {zero, negative, carry, overflow, err}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] w, input logic [4:0] f);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.w = w; v.f = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        vecs.push_back(mk(4'b0010, 64'h82C639269A, 64'h152672E37E, 64'h97ECAC0A18, 5'b00000));
        vecs.push_back(mk(4'b0110, 64'h7F0C4B3F, 64'h5A0E7A39, 64'h24FDD106, 5'b00100));
        vecs.push_back(mk(4'b0110, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 5'b01000));
        vecs.push_back(mk(4'b0010, 64'h7FFFFFFFFFFFFFFF, 64'h1, 64'h8000000000000000, 5'b01010));
        vecs.push_back(mk(4'b0111, 64'h1234, 64'h0, 64'h0, 5'b10000));
        vecs.push_back(mk(4'b0011, 64'h1, 64'd63, 64'h8000000000000000, 5'b01000));
        vecs.push_back(mk(4'b0100, 64'h8000000000000000, 64'h43, 64'h1000000000000000, 5'b00000));
        vecs.push_back(mk(4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 5'b00000));
        vecs.push_back(mk(4'b0001, 64'hF0F0, 64'h0F0F, 64'hFFFF, 5'b00000));
        vecs.push_back(mk(4'b1111, 64'h5, 64'h7, 64'h0, 5'b10001));
        vecs.push_back(mk(4'b0010, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 5'b10100));
        vecs.push_back(mk(4'b0110, 64'h8000000000000000, 64'h1, 64'h7FFFFFFFFFFFFFFF, 5'b00110));
`ifndef SEQ_ALU_MUL_EN
        vecs.push_back(mk(4'b0101, 64'h3, 64'h4, 64'h0, 5'b10001));
`endif

        Reset = 1'b1; in_valid = 1'b0; busA = '0; busB = '0; ctrl = '0;
        #2;
        chk("rst_w", busW, 64'h0);
        chk("rst_flags", {zero, negative, carry, overflow, err}, 64'b10000);
        chk("rst_hs", {out_valid, in_ready}, 64'b00);
        tick(); tick();
        Reset = 1'b0;
        tick();
        chk("rdy_after_rst", in_ready, 64'h1);

        // Back-to-back single-cycle ops, one per clock
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1; ctrl = vecs[i].op; busA = vecs[i].a; busB = vecs[i].b;
            tick();
            chk($sformatf("v%0d_w", i), busW, vecs[i].w);
            chk($sformatf("v%0d_f", i), {zero, negative, carry, overflow, err}, 64'(vecs[i].f));
            chk($sformatf("v%0d_hs", i), {out_valid, in_ready}, 64'b11);
        end
        in_valid = 1'b0;
        tick();
        chk("ov_pulse", out_valid, 64'h0);
        chk("hold_w", busW, vecs[vecs.size()-1].w);

`ifdef SEQ_ALU_MUL_EN
        begin
            int lat;
            bit seen_busy;
            bit bad_ov;
            lat = 0; seen_busy = 1'b1; bad_ov = 1'b0;
            in_valid = 1'b1; ctrl = 4'b0101; busA = 64'h12345678; busB = 64'h10;
            tick();
            // stray request during MUL_RUN, must be ignored
            ctrl = 4'b0010; busA = 64'hAAAA; busB = 64'h1;
            for (int k = 1; k <= 200; k++) begin
                tick();
                if (k == 10) in_valid = 1'b0;
                if (out_valid) begin lat = k; break; end
                if (in_ready) seen_busy = 1'b0;
            end
            chk("mul_lat", 64'(lat), 64'd64);
            chk("mul_w", busW, 64'h123456780);
            chk("mul_flags", {zero, negative, carry, overflow, err}, 64'b00000);
            chk("mul_busy", 64'(seen_busy), 64'h1);
            chk("mul_rdy_back", in_ready, 64'h1);
            for (int k = 0; k < 3; k++) begin
                tick();
                if (out_valid) bad_ov = 1'b1;
            end
            chk("stray_ignored_ov", 64'(bad_ov), 64'h0);
            chk("stray_ignored_w", busW, 64'h123456780);
        end
`endif

        // Reset abort: establish a nonzero result first
        in_valid = 1'b1; ctrl = 4'b0010; busA = 64'h10; busB = 64'h20;
        tick();
        chk("pre_rst_w", busW, 64'h30);
`ifdef SEQ_ALU_MUL_EN
        ctrl = 4'b0101; busA = 64'h3; busB = 64'h5;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("mid_mul_busy", {out_valid, in_ready}, 64'b00);
`else
        in_valid = 1'b0;
        tick();
`endif
        Reset = 1'b1;
        #1;
        chk("abort_w", busW, 64'h0);
        chk("abort_flags", {zero, negative, carry, overflow, err}, 64'b10000);
        chk("abort_hs", {out_valid, in_ready}, 64'b00);
        tick();
        Reset = 1'b0;
        begin
            bit bad_ov;
            bad_ov = 1'b0;
            for (int k = 0; k < 70; k++) begin
                tick();
                if (out_valid) bad_ov = 1'b1;
            end
            chk("abort_no_ov", 64'(bad_ov), 64'h0);
        end
        chk("abort_rdy", in_ready, 64'h1);
        in_valid = 1'b1; ctrl = 4'b0010; busA = 64'd2; busB = 64'd3;
        tick();
        in_valid = 1'b0;
        chk("post_rst_add", busW, 64'd5);
        chk("post_rst_ov", out_valid, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
